alu_serial_responder: RTL and testbench

- Request/response executor for the 32-bit ALU operation set.
- Accepts one operation (a, b, cin, Aluop) on a valid/ready request channel, then computes it over several cycles, SLICE_W bits per cycle, LSB slice first, with the carry chained between slices.
- Returns R and the cout/S/V flags on a valid/ready response channel.
- Sits behind a stimulus or sequencer block as the responder end of the ALU operation interface.

---
 rtl/alu_serial_responder.sv | 179 +++++++++++++++++
 tb/tb_alu_serial_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_serial_responder.sv
// Serial ALU responder: accepts one op on a valid/ready request channel, computes it
// SLICE_W bits per cycle (LSB first), returns R/cout/S/V. Optional Z flag: ALU_SERIAL_ZERO_FLAG_EN.
//
// state | meaning
// IDLE  | ready for a request
// RUN   | processing one slice per edge, carry chained in a register
// DONE  | response held until rsp_ready
module alu_serial_responder #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic [2:0]        Aluop,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] R,
  output logic              cout,
  output logic              S,
  output logic              V
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  ,
  output logic              Z
`endif
);

  localparam int NS = DATA_W / SLICE_W;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_OR  = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] a_q, b_q;
  logic [2:0]        op_q;
  logic              carry_q;
  logic [CW-1:0]     cnt_q;
  logic              zacc_q;

  logic [SLICE_W-1:0] a_sl, bx_sl, sum_sl, res_sl;
  logic [SLICE_W:0]   c;
  logic               last, is_arith, is_addsub, v_sl;
  logic [DATA_W-1:0]  r_nxt;
  logic               z_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Slice datapath: operands are shifted down so the active slice is always at the bottom
  always_comb begin
    is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
    is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
    last      = (cnt_q == CW'(NS - 1));
    a_sl      = a_q[SLICE_W-1:0];
    bx_sl     = ((op_q == OP_SUB) || (op_q == OP_SLT)) ? ~b_q[SLICE_W-1:0] : b_q[SLICE_W-1:0];
    c         = '0;
    sum_sl    = '0;
    c[0]      = carry_q;
    for (int i = 0; i < SLICE_W; i++) begin
      sum_sl[i] = a_sl[i] ^ bx_sl[i] ^ c[i];
      c[i+1]    = (a_sl[i] & bx_sl[i]) | (a_sl[i] & c[i]) | (bx_sl[i] & c[i]);
    end
    v_sl = c[SLICE_W-1] ^ c[SLICE_W];

    case (op_q)
      OP_ADD, OP_SUB, OP_SLT: res_sl = sum_sl;
      OP_XOR:                 res_sl = a_q[SLICE_W-1:0] ^ b_q[SLICE_W-1:0];
      OP_NOR:                 res_sl = ~(a_q[SLICE_W-1:0] | b_q[SLICE_W-1:0]);
      OP_AND:                 res_sl = a_q[SLICE_W-1:0] & b_q[SLICE_W-1:0];
      OP_OR:                  res_sl = a_q[SLICE_W-1:0] | b_q[SLICE_W-1:0];
      default:                res_sl = '0;
    endcase

    r_nxt = R;
    for (int k = 0; k < NS; k++) begin
      if (cnt_q == CW'(k)) r_nxt[k*SLICE_W +: SLICE_W] = res_sl;
    end
    z_nxt = zacc_q & (res_sl == '0);

    // SLT replaces the whole difference with the signed less-than bit
    if (last && (op_q == OP_SLT)) begin
      r_nxt    = '0;
      r_nxt[0] = sum_sl[SLICE_W-1] ^ v_sl;
      z_nxt    = ~r_nxt[0];
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      zacc_q  <= 1'b0;
      R       <= '0;
      cout    <= 1'b0;
      S       <= 1'b0;
      V       <= 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      Z       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q    <= a;
            b_q    <= b;
            op_q   <= Aluop;
            cnt_q  <= '0;
            zacc_q <= 1'b1;
            case (Aluop)
              OP_ADD:         carry_q <= cin;
              OP_SUB, OP_SLT: carry_q <= 1'b1;
              default:        carry_q <= 1'b0;
            endcase
          end
        end
        RUN: begin
          a_q     <= a_q >> SLICE_W;
          b_q     <= b_q >> SLICE_W;
          carry_q <= c[SLICE_W];
          zacc_q  <= z_nxt;
          R       <= r_nxt;
          cnt_q   <= last ? '0 : cnt_q + CW'(1);
          if (last) begin
            cout <= is_arith  ? c[SLICE_W] : 1'b0;
            V    <= is_addsub ? v_sl       : 1'b0;
            S    <= r_nxt[DATA_W-1];
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            Z    <= z_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_responder.sv
// Directed, table-driven bench for alu_serial_responder plus backpressure and
// mid-operation reset sequences.
module tb_alu_serial_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic [2:0]  Aluop = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] R;
  logic        cout, S, V;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic        Z;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_serial_responder dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .a(a), .b(b), .cin(cin), .Aluop(Aluop), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .R(R), .cout(cout), .S(S), .V(V)
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    , .Z(Z)
`endif
  );

  typedef struct {
    string       name;
    logic [31:0] a, b;
    logic        cin;
    logic [2:0]  op;
    logic [31:0] r;
    logic        co, s, v;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Accept one request; returns with the clock #1 after the accept edge.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic tc, input logic [2:0] top);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; Aluop = top; req_valid = 1'b1;
    chk("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    // scramble operands to show they are not re-sampled
    a = ~ta; b = ~tb_; cin = ~tc; Aluop = ~top;
  endtask

  // Waits for rsp_valid, checking latency against NS=8.
  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid) break;
      chk({name, "_req_ready_run"}, {31'b0, req_ready}, 32'd0);
    end
    chk({name, "_latency"}, n, 32'd8);
  endtask

  task automatic check_rsp(input string name, input logic [31:0] er, input logic eco,
                           input logic es, input logic ev);
    chk({name, "_R"}, R, er);
    chk({name, "_cout"}, {31'b0, cout}, {31'b0, eco});
    chk({name, "_S"}, {31'b0, S}, {31'b0, es});
    chk({name, "_V"}, {31'b0, V}, {31'b0, ev});
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    chk({name, "_Z"}, {31'b0, Z}, {31'b0, (er == 32'd0)});
`endif
    chk({name, "_req_ready_done"}, {31'b0, req_ready}, 32'd0);
  endtask

  task automatic ack(input string name);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({name, "_rsp_valid_after_ack"}, {31'b0, rsp_valid}, 32'd0);
    chk({name, "_req_ready_after_ack"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{"and",      32'hAAAAAAAA, 32'h55555555, 1'b0, 3'b110, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"add_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 3'b000, 32'h80000000, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{"sub",      32'h00000005, 32'h00000007, 1'b1, 3'b010, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{"slt_neg",  32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b100, 32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{"add_cout", 32'hFFFFFFFF, 32'h00000000, 1'b1, 3'b000, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{"add_cin",  32'h00000001, 32'h00000002, 1'b1, 3'b000, 32'h00000004, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"sub_ovf",  32'h80000000, 32'h00000001, 1'b0, 3'b010, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{"slt_ovf",  32'h80000000, 32'h00000001, 1'b0, 3'b100, 32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{"slt_false",32'h00000001, 32'hFFFFFFFF, 1'b1, 3'b100, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{"xor",      32'h12345678, 32'hFFFF0000, 1'b1, 3'b001, 32'hEDCB5678, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{"nor",      32'h0F0F0F0F, 32'h00FF00FF, 1'b0, 3'b101, 32'hF000F000, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{"or",       32'h0F0F0000, 32'h000000F0, 1'b0, 3'b111, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{"reserved", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 3'b011, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{"add_wrap", 32'h80000000, 32'h80000000, 1'b0, 3'b000, 32'h00000000, 1'b1, 1'b0, 1'b1};

    #12;
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_R", R, 32'd0);
    chk("reset_flags", {29'b0, cout, S, V}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op);
      wait_rsp(vecs[i].name);
      check_rsp(vecs[i].name, vecs[i].r, vecs[i].co, vecs[i].s, vecs[i].v);
      ack(vecs[i].name);
    end

    // Backpressure: hold rsp_ready low, poke req_valid which must be ignored
    send(32'h0F0F0000, 32'h000000F0, 1'b0, 3'b111);
    wait_rsp("bp");
    req_valid = 1'b1; a = 32'h12345678; b = 32'h9ABCDEF0; Aluop = 3'b000;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid_hold", {31'b0, rsp_valid}, 32'd1);
      check_rsp("bp_hold", 32'h0F0F00F0, 1'b0, 1'b0, 1'b0);
    end
    req_valid = 1'b0;
    ack("bp");
    chk("bp_R_after_ack", R, 32'h0F0F00F0);

    // Reset in the middle of RUN
    send(32'h11111111, 32'h22222222, 1'b0, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_R", R, 32'd0);
    chk("rst_mid_flags", {29'b0, cout, S, V}, 32'd0);
    chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("rst_no_response", {31'b0, rsp_valid}, 32'd0);
    end
    send(32'hFFFF0000, 32'h0000FFFF, 1'b0, 3'b001);
    wait_rsp("post_rst_xor");
    check_rsp("post_rst_xor", 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    ack("post_rst_xor");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
